// File: rtl/gpr_file_mp.sv
// Multi-port GPR file: clear-sweep FSM after reset, highest write port wins on conflicts.
// Optional same-cycle write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module gpr_rd_port #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [DEPTH-1:0][DW-1:0] mem_i,
  input  logic                     ready_i,
  input  logic [AW-1:0]            addr_i,
  input  logic                     fwd_vld_i,
  input  logic [DW-1:0]            fwd_data_i,
  output logic [DW-1:0]            data_o
);
  always_comb begin
    data_o = '0;
    if (ready_i && !(ZERO_REG != 0 && addr_i == '0))
      data_o = fwd_vld_i ? fwd_data_i : mem_i[addr_i];
  end
endmodule

module gpr_file_mp #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD*DW-1:0] rd_data,
  input  logic [NUM_WR-1:0]    wr_en,
  input  logic [NUM_WR*AW-1:0] wr_addr,
  input  logic [NUM_WR*DW-1:0] wr_data,
  output logic                 ready
);
  typedef enum logic {CLEAR, READY} state_e;

  state_e                  state_q, state_d;
  logic [AW-1:0]           clr_cnt_q, clr_cnt_d;
  logic                    ready_q, ready_d;
  logic [DEPTH-1:0][DW-1:0] mem_q, mem_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == AW'(DEPTH-1)) begin
          state_d = READY;
          ready_d = 1'b1;
        end
      end
      READY:   ;
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  // Later ports overwrite earlier ones in the loop, so the highest index wins.
  always_comb begin
    mem_d = mem_q;
    if (!rst) begin
      if (state_q == CLEAR) begin
        mem_d[clr_cnt_q] = '0;
      end else begin
        for (int j = 0; j < NUM_WR; j++)
          if (wr_en[j] && !(ZERO_REG != 0 && wr_addr[j*AW +: AW] == '0))
            mem_d[wr_addr[j*AW +: AW]] = wr_data[j*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  assign ready = ready_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0] ra;
    logic          fwd_vld;
    logic [DW-1:0] fwd_data;
    assign ra = rd_addr[i*AW +: AW];
`ifdef REGFILE_BYPASS_EN
    always_comb begin
      fwd_vld  = 1'b0;
      fwd_data = '0;
      for (int j = 0; j < NUM_WR; j++)
        if (wr_en[j] && wr_addr[j*AW +: AW] == ra) begin
          fwd_vld  = 1'b1;
          fwd_data = wr_data[j*DW +: DW];
        end
    end
`else
    assign fwd_vld  = 1'b0;
    assign fwd_data = '0;
`endif
    gpr_rd_port #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .ZERO_REG(ZERO_REG)) u_rd (
      .mem_i      (mem_q),
      .ready_i    (ready_q),
      .addr_i     (ra),
      .fwd_vld_i  (fwd_vld),
      .fwd_data_i (fwd_data),
      .data_o     (rd_data[i*DW +: DW])
    );
  end
endmodule
